// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects and FSM states.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam int TMR_W = 8;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_LU  = 2'd1,
    ST_MW  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: hazard inputs from the stages,
// keep/nop/redirect/forward controls back to them.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic             ex_regwrite;
  logic             ex_is_load;
  logic [4:0]       mem_rd;
  logic             mem_regwrite;
  logic [4:0]       wb_rd;
  logic             wb_regwrite;
  logic             mem_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             keep_pc;
  logic             keep_ifid;
  logic             keep_idex;
  logic             keep_exmem;
  logic             keep_memwb;
  logic             nop_ifid;
  logic             nop_idex;
  logic             nop_exmem;
  logic             pc_sel;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
           ex_regwrite, ex_is_load, mem_rd, mem_regwrite, wb_rd, wb_regwrite,
           mem_taken, mem_req, mem_ready,
    input  keep_pc, keep_ifid, keep_idex, keep_exmem, keep_memwb, nop_ifid,
           nop_idex, nop_exmem, pc_sel, fwd_a, fwd_b, mem_err, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
           ex_regwrite, ex_is_load, mem_rd, mem_regwrite, wb_rd, wb_regwrite,
           mem_taken, mem_req, mem_ready,
    output keep_pc, keep_ifid, keep_idex, keep_exmem, keep_memwb, nop_ifid,
           nop_idex, nop_exmem, pc_sel, fwd_a, fwd_b, mem_err, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// EX operand forwarding select for one source register; EX/MEM beats MEM/WB, x0 never forwards.
module pipe_hazard_ctrl_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  output logic [1:0] fwd
);

  // pick the youngest in-flight writer of rs
  always_comb begin
    fwd = FWD_REG;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == rs))
      fwd = FWD_EXMEM;
    else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs))
      fwd = FWD_MEMWB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: load-use bubble, MEM-resolved branch flush,
// data-memory wait with timeout flag, and a stall-cycle counter.
//
// state  | meaning
// ST_RUN | normal flow; detects all three hazards
// ST_LU  | bubble sits in ID/EX; release the ID hold
// ST_MW  | data memory busy; freeze PC..EX/MEM, let WB retire
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             err_reg, err_nxt;
  logic [CNT_W-1:0] stall_reg;
  logic             lu_haz, mw_haz;
  logic             hold, flush, lu_stall;
  logic [1:0]       fwd_a_raw, fwd_b_raw;

  assign lu_haz = bus.ex_is_load && bus.ex_regwrite && (bus.ex_rd != 5'd0) &&
                  ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                   (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
  assign mw_haz = bus.mem_req && !bus.mem_ready;

  pipe_hazard_ctrl_fwd_sel u_fwd_a (
    .rs(bus.ex_rs1), .mem_rd(bus.mem_rd), .mem_regwrite(bus.mem_regwrite),
    .wb_rd(bus.wb_rd), .wb_regwrite(bus.wb_regwrite), .fwd(fwd_a_raw)
  );

  pipe_hazard_ctrl_fwd_sel u_fwd_b (
    .rs(bus.ex_rs2), .mem_rd(bus.mem_rd), .mem_regwrite(bus.mem_regwrite),
    .wb_rd(bus.wb_rd), .wb_regwrite(bus.wb_regwrite), .fwd(fwd_b_raw)
  );

  // next-state, timer and hazard action decode
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    err_nxt   = err_reg;
    hold      = 1'b0;
    flush     = 1'b0;
    lu_stall  = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (mw_haz) begin
          hold      = 1'b1;
          state_nxt = ST_MW;
          timer_nxt = TMR_W'(1);
        end else if (bus.mem_taken) begin
          flush = 1'b1;
        end else if (lu_haz) begin
          lu_stall  = 1'b1;
          state_nxt = ST_LU;
        end
      end
      ST_LU: begin
        state_nxt = ST_RUN;
        flush     = bus.mem_taken;
      end
      ST_MW: begin
        if (!bus.mem_ready) begin
          hold = 1'b1;
          if (timer != {TMR_W{1'b1}})
            timer_nxt = timer + TMR_W'(1);
          if (timer == TMR_W'(MEM_TIMEOUT - 1))
            err_nxt = 1'b1;
        end else begin
          state_nxt = ST_RUN;
          timer_nxt = '0;
          flush     = bus.mem_taken;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // stage controls; reset forces bubbles everywhere and no holds
  always_comb begin
    bus.keep_pc    = rst & (hold | lu_stall);
    bus.keep_ifid  = rst & (hold | lu_stall);
    bus.keep_idex  = rst & hold;
    bus.keep_exmem = rst & hold;
    bus.keep_memwb = 1'b0;
    bus.nop_ifid   = !rst | flush;
    bus.nop_idex   = !rst | flush | lu_stall;
    bus.nop_exmem  = !rst | flush;
    bus.pc_sel     = rst & flush;
    bus.fwd_a      = rst ? fwd_a_raw : FWD_REG;
    bus.fwd_b      = rst ? fwd_b_raw : FWD_REG;
  end

  assign bus.mem_err      = err_reg;
  assign bus.stall_cycles = stall_reg;

  // state, timer, sticky error and stall counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_RUN;
      timer     <= '0;
      err_reg   <= 1'b0;
      stall_reg <= '0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      err_reg <= err_nxt;
      if (bus.keep_pc)
        stall_reg <= stall_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expected controls.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // {keep_pc, keep_ifid, keep_idex, keep_exmem, keep_memwb, nop_ifid, nop_idex, nop_exmem, pc_sel}
  logic [8:0] ctl;
  assign ctl = {bus.keep_pc, bus.keep_ifid, bus.keep_idex, bus.keep_exmem, bus.keep_memwb,
                bus.nop_ifid, bus.nop_idex, bus.nop_exmem, bus.pc_sel};

  localparam logic [8:0] CTL_NONE  = 9'b00000_000_0;
  localparam logic [8:0] CTL_LU    = 9'b11000_010_0;
  localparam logic [8:0] CTL_MW    = 9'b11110_000_0;
  localparam logic [8:0] CTL_FLUSH = 9'b00000_111_1;
  localparam logic [8:0] CTL_RST   = 9'b00000_111_0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.ex_rs1 = 0; bus.ex_rs2 = 0; bus.ex_rd = 0; bus.ex_regwrite = 0; bus.ex_is_load = 0;
    bus.mem_rd = 0; bus.mem_regwrite = 0; bus.wb_rd = 0; bus.wb_regwrite = 0;
    bus.mem_taken = 0; bus.mem_req = 0; bus.mem_ready = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    bus.ex_is_load = 1; bus.ex_regwrite = 1; bus.ex_rd = rd;
    bus.id_use_rs1 = 1; bus.id_rs1 = 5;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    bus.ex_rs1 = 7; bus.mem_rd = 7; bus.mem_regwrite = 1;
    step();
    step();
    check("rst_ctl", 32'(ctl), 32'(CTL_RST));
    check("rst_fwd_a", 32'(bus.fwd_a), 32'(FWD_REG));
    check("rst_stall", bus.stall_cycles, 0);
    check("rst_err", 32'(bus.mem_err), 0);
    rst = 1'b1;
    clear_inputs();
    #1;
    check("run_idle", 32'(ctl), 32'(CTL_NONE));

    // load-use on rs1
    set_load_use(5);
    #1;
    check("lu_stall", 32'(ctl), 32'(CTL_LU));
    step();
    check("lu_bubble", 32'(ctl), 32'(CTL_NONE));
    step();
    clear_inputs();
    #1;
    check("lu_back_run", 32'(ctl), 32'(CTL_NONE));
    check("lu_stall_cnt", bus.stall_cycles, 1);

    // x0 load, and a non-used rs1 match
    set_load_use(0);
    #1;
    check("x0_load", 32'(ctl), 32'(CTL_NONE));
    set_load_use(5);
    bus.id_use_rs1 = 0;
    #1;
    check("unused_rs1", 32'(ctl), 32'(CTL_NONE));
    bus.id_use_rs2 = 1; bus.id_rs2 = 5;
    #1;
    check("lu_rs2", 32'(ctl), 32'(CTL_LU));
    step();
    clear_inputs();
    step();
    check("lu_rs2_cnt", bus.stall_cycles, 2);

    // taken branch beats load-use
    set_load_use(5);
    bus.mem_taken = 1;
    #1;
    check("taken_flush", 32'(ctl), 32'(CTL_FLUSH));
    step();
    clear_inputs();
    #1;
    check("taken_one_cycle", 32'(ctl), 32'(CTL_NONE));
    check("taken_no_stall", bus.stall_cycles, 2);

    // memory wait, ready in 4th cycle together with a taken branch
    bus.mem_req = 1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      check("mw_hold", 32'(ctl), 32'(CTL_MW));
      step();
    end
    bus.mem_ready = 1; bus.mem_taken = 1;
    #1;
    check("mw_release_taken", 32'(ctl), 32'(CTL_FLUSH));
    step();
    clear_inputs();
    #1;
    check("mw_back_run", 32'(ctl), 32'(CTL_NONE));
    check("mw_stall_cnt", bus.stall_cycles, 5);
    check("mw_no_err", 32'(bus.mem_err), 0);

    // timeout: error sets after the 16th held edge and sticks
    bus.mem_req = 1;
    for (int i = 1; i <= 20; i++) begin
      #1;
      check("to_hold", 32'(ctl), 32'(CTL_MW));
      step();
      check("to_err", 32'(bus.mem_err), (i >= 16) ? 32'd1 : 32'd0);
    end
    check("to_stall_cnt", bus.stall_cycles, 25);

    // reset in the middle of the wait
    rst = 1'b0;
    #1;
    check("mid_rst_ctl", 32'(ctl), 32'(CTL_RST));
    step();
    rst = 1'b1;
    clear_inputs();
    #1;
    check("post_rst_run", 32'(ctl), 32'(CTL_NONE));
    check("post_rst_err", 32'(bus.mem_err), 0);
    check("post_rst_stall", bus.stall_cycles, 0);

    // forwarding
    bus.ex_rs1 = 7; bus.ex_rs2 = 7; bus.mem_rd = 7; bus.wb_rd = 7;
    bus.mem_regwrite = 1; bus.wb_regwrite = 1;
    #1;
    check("fwd_a_exmem", 32'(bus.fwd_a), 32'(FWD_EXMEM));
    check("fwd_b_exmem", 32'(bus.fwd_b), 32'(FWD_EXMEM));
    bus.mem_regwrite = 0;
    #1;
    check("fwd_a_memwb", 32'(bus.fwd_a), 32'(FWD_MEMWB));
    check("fwd_b_memwb", 32'(bus.fwd_b), 32'(FWD_MEMWB));
    bus.mem_regwrite = 1; bus.mem_rd = 0;
    #1;
    check("fwd_a_exmem_x0", 32'(bus.fwd_a), 32'(FWD_MEMWB));
    bus.ex_rs1 = 0; bus.ex_rs2 = 0; bus.wb_rd = 0;
    #1;
    check("fwd_a_x0", 32'(bus.fwd_a), 32'(FWD_REG));
    check("fwd_b_x0", 32'(bus.fwd_b), 32'(FWD_REG));
    bus.ex_rs1 = 7; bus.ex_rs2 = 9; bus.mem_rd = 7; bus.wb_rd = 9;
    #1;
    check("fwd_a_split", 32'(bus.fwd_a), 32'(FWD_EXMEM));
    check("fwd_b_split", 32'(bus.fwd_b), 32'(FWD_MEMWB));
    bus.wb_regwrite = 0;
    #1;
    check("fwd_b_nowrite", 32'(bus.fwd_b), 32'(FWD_REG));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
